ss_scroll_controller: RTL and testbench

Sequencer and arbiter for the write port of the memory-mapped I/O driver on page 0x80. The block holds a 16-entry message buffer and scrolls it across the eight seven-segment digits by issuing driver write cycles at a programmable rate. It shares the driver port with the CPU, and the CPU always has priority. It sits between the CPU bus and the I/O driver; push-button reads and LED writes pass through unchanged.

---
 rtl/io_map_pkg.sv | 38 +++
 rtl/scroll_tick_gen.sv | 54 +++++
 rtl/ss_scroll_controller.sv | 169 ++++++++++++++++
 tb/tb_ss_scroll_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// I/O page map, scroll FSM state type and buffer geometry for the scroll controller.
// No logic, so no latency.
// No flow control; address decode helpers only.
package io_map_pkg;

    // Driver-side addresses (page-relative)
    localparam logic [7:0] ADDR_SS0     = 8'h00;
    localparam logic [7:0] ADDR_SS1     = 8'h01;
    localparam logic [7:0] ADDR_SS2     = 8'h02;
    localparam logic [7:0] ADDR_SS3     = 8'h03;
    localparam logic [7:0] ADDR_SS4     = 8'h04;
    localparam logic [7:0] ADDR_SS5     = 8'h05;
    localparam logic [7:0] ADDR_SS6     = 8'h06;
    localparam logic [7:0] ADDR_SS7     = 8'h07;
    localparam logic [7:0] ADDR_LEFT    = 8'h08;
    localparam logic [7:0] ADDR_RIGHT   = 8'h09;
    localparam logic [7:0] ADDR_PB_BASE = 8'h10;

    // Controller registers (absorbed, never forwarded to the driver)
    localparam logic [7:0] ADDR_CTRL     = 8'h20;
    localparam logic [7:0] ADDR_LEN      = 8'h21;
    localparam logic [7:0] ADDR_RATE     = 8'h22;
    localparam logic [7:0] ADDR_OFFSET   = 8'h23;
    localparam logic [7:0] ADDR_BUF_BASE = 8'h30;

    localparam int BUF_DEPTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } scroll_state_t;

    // True for 0x20..0x23 and 0x30..0x3F
    function automatic logic is_ctrl_addr(input logic [7:0] addr);
        return (addr[7:2] == ADDR_CTRL[7:2]) || (addr[7:4] == ADDR_BUF_BASE[7:4]);
    endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Prescaler (TICK_DIV clocks per tick) plus step counter (rate ticks per step).
// step is combinational in the cycle of the terminal tick; one cycle wide.
// No backpressure: a step nobody consumes is simply lost by the consumer.
module scroll_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic [7:0] rate,
    output logic       step
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic [7:0]    step_cnt;
    logic [7:0]    rate_eff;
    logic          tick;

    // RATE of 0 behaves as 1
    assign rate_eff = (rate == 8'd0) ? 8'd1 : rate;
    assign tick     = en && (presc == PRESC_MAX);
    // >= so that lowering RATE below the current count still steps promptly
    assign step     = tick && (step_cnt >= (rate_eff - 8'd1));

    // Prescaler: free-runs while enabled, held cleared while disabled
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc <= '0;
        end else if (!en) begin
            presc <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Step counter: counts ticks, wraps when a step is issued
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            step_cnt <= 8'd0;
        end else if (!en) begin
            step_cnt <= 8'd0;
        end else if (step) begin
            step_cnt <= 8'd0;
        end else if (tick) begin
            step_cnt <= step_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ss_scroll_controller.sv
// Scrolls a 16-entry message across eight 7-seg digits, sharing the driver port with the CPU.
// Driver outputs combinational from state and CPU inputs; a frame is 8 write cycles plus stalls.
// CPU always wins the driver port; the engine stalls (holds digit index) while preempted.
module ss_scroll_controller
    import io_map_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       cpu_req,
    input  logic       cpu_read_en,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic       drv_read_en,
    output logic [7:0] drv_addr,
    output logic [7:0] drv_din,
    output logic       ctrl_hit,
    output logic [7:0] ctrl_dout
);

    scroll_state_t state, nxt_state;

    logic       en;
    logic [3:0] len;
    logic [7:0] rate;
    logic [3:0] offset;
    logic [7:0] msg_buf [BUF_DEPTH];
    logic       step_pend;
    logic [2:0] d;

    logic       is_ctrl;
    logic       fwd;
    logic       ctrl_wr;
    logic       en_nxt;
    logic       step;
    logic       busy;
    logic       engine_wr;
    logic       frame_start;
    logic       frame_done;
    logic [4:0] length;
    logic [4:0] pos;
    logic [4:0] idx;

    assign is_ctrl = is_ctrl_addr(cpu_addr);
    assign fwd     = cpu_req && !is_ctrl;
    assign ctrl_wr = cpu_req && !cpu_read_en && is_ctrl;
    assign busy    = (state == FRAME);
    // Value EN holds after this edge; lets an EN clear abort the frame at that same edge
    assign en_nxt  = (ctrl_wr && (cpu_addr == ADDR_CTRL)) ? cpu_din[0] : en;

    // Buffer index for the current digit; offset never exceeds len so pos stays < 32
    assign length = {1'b0, len} + 5'd1;
    assign pos    = {1'b0, offset} + {2'b00, d};
    assign idx    = pos % length;

    scroll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .nrst (nrst),
        .en   (en),
        .rate (rate),
        .step (step)
    );

    // Configuration registers written by the CPU
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            en   <= 1'b0;
            len  <= 4'hF;
            rate <= 8'd1;
        end else if (ctrl_wr) begin
            if (cpu_addr == ADDR_CTRL) en   <= cpu_din[0];
            if (cpu_addr == ADDR_LEN)  len  <= cpu_din[3:0];
            if (cpu_addr == ADDR_RATE) rate <= cpu_din;
        end
    end

    // Message buffer
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < BUF_DEPTH; i++) msg_buf[i] <= 8'd0;
        end else if (ctrl_wr && (cpu_addr[7:4] == ADDR_BUF_BASE[7:4])) begin
            msg_buf[cpu_addr[3:0]] <= cpu_din;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= nxt_state;
    end

    // FSM next state and engine write strobe
    always_comb begin
        nxt_state   = state;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        engine_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (en && en_nxt && step_pend) begin
                    nxt_state   = FRAME;
                    frame_start = 1'b1;
                end
            end
            FRAME: begin
                engine_wr  = en && !fwd;
                frame_done = engine_wr && (d == 3'd7);
                if (!en_nxt || frame_done) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Digit index, scroll offset and pending-step flag
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            d         <= 3'd0;
            offset    <= 4'd0;
            step_pend <= 1'b0;
        end else begin
            if (frame_start)    d <= 3'd0;
            else if (engine_wr) d <= d + 3'd1;

            if (ctrl_wr && (cpu_addr == ADDR_LEN)) offset <= 4'd0;
            else if (frame_done)                   offset <= (offset >= len) ? 4'd0 : offset + 4'd1;

            if (!en_nxt)          step_pend <= 1'b0;
            else if (step)        step_pend <= 1'b1;
            else if (frame_start) step_pend <= 1'b0;
        end
    end

    // Driver port mux: forwarded CPU cycle, else engine write, else idle read
    always_comb begin
        drv_read_en = 1'b1;
        drv_addr    = 8'd0;
        drv_din     = 8'd0;
        if (fwd) begin
            drv_read_en = cpu_read_en;
            drv_addr    = cpu_addr;
            drv_din     = cpu_din;
        end else if (engine_wr) begin
            drv_read_en = 1'b0;
            drv_addr    = {5'd0, d};
            drv_din     = msg_buf[idx[3:0]];
        end
    end

    // Controller register read-back
    always_comb begin
        ctrl_hit  = cpu_req && cpu_read_en && is_ctrl;
        ctrl_dout = 8'd0;
        if (ctrl_hit) begin
            if (cpu_addr[7:4] == ADDR_BUF_BASE[7:4]) begin
                ctrl_dout = msg_buf[cpu_addr[3:0]];
            end else begin
                case (cpu_addr)
                    ADDR_CTRL:   ctrl_dout = {6'd0, busy, en};
                    ADDR_LEN:    ctrl_dout = {4'd0, len};
                    ADDR_RATE:   ctrl_dout = rate;
                    ADDR_OFFSET: ctrl_dout = {4'd0, offset};
                    default:     ctrl_dout = 8'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ss_scroll_controller.sv
// Directed bench for ss_scroll_controller with TICK_DIV=4.
// Inputs change on the falling edge; outputs are checked 1 ns later.
// Expected values are hand-computed constants.
module tb_ss_scroll_controller;

    logic       clk;
    logic       nrst;
    logic       cpu_req;
    logic       cpu_read_en;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_din;
    logic       drv_read_en;
    logic [7:0] drv_addr;
    logic [7:0] drv_din;
    logic       ctrl_hit;
    logic [7:0] ctrl_dout;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_f1 [8];
    logic [7:0] exp_f2 [8];

    ss_scroll_controller #(.TICK_DIV(4)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .cpu_req     (cpu_req),
        .cpu_read_en (cpu_read_en),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .drv_read_en (drv_read_en),
        .drv_addr    (drv_addr),
        .drv_din     (drv_din),
        .ctrl_hit    (ctrl_hit),
        .ctrl_dout   (ctrl_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_idle();
        cpu_req     = 1'b0;
        cpu_read_en = 1'b1;
        cpu_addr    = 8'd0;
        cpu_din     = 8'd0;
    endtask

    // Advance to the next falling edge with the CPU idle
    task automatic adv();
        @(negedge clk);
        cpu_idle();
    endtask

    // One-cycle controller write; the driver must not see it
    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] v);
        cpu_req     = 1'b1;
        cpu_read_en = 1'b0;
        cpu_addr    = a;
        cpu_din     = v;
        #1;
        chk($sformatf("nofwd_%0h", a), {7'd0, drv_read_en}, 8'd1);
        adv();
    endtask

    // One-cycle controller read with expected data
    task automatic cpu_rd(input string tag, input logic [7:0] a, input logic [7:0] v);
        cpu_req     = 1'b1;
        cpu_read_en = 1'b1;
        cpu_addr    = a;
        cpu_din     = 8'd0;
        #1;
        chk({tag, "_hit"}, {7'd0, ctrl_hit}, 8'd1);
        chk({tag, "_dout"}, ctrl_dout, v);
    endtask

    task automatic expect_wr(input string tag, input logic [7:0] a, input logic [7:0] v);
        chk({tag, "_rden"}, {7'd0, drv_read_en}, 8'd0);
        chk({tag, "_addr"}, drv_addr, a);
        chk({tag, "_din"}, drv_din, v);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_rden"}, {7'd0, drv_read_en}, 8'd1);
        chk({tag, "_addr"}, drv_addr, 8'd0);
        chk({tag, "_din"}, drv_din, 8'd0);
    endtask

    initial begin
        exp_f1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4};
        // second frame, offset 1: d=2..7 -> BUF[3,0,1,2,3,0]
        exp_f2 = '{8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1};

        nrst = 1'b0;
        cpu_idle();
        #1;
        expect_idle("rst");
        chk("rst_hit", {7'd0, ctrl_hit}, 8'd0);
        chk("rst_dout", ctrl_dout, 8'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // Register defaults and setup
        cpu_rd("rate_dflt", 8'h22, 8'h01); adv();
        cpu_rd("len_dflt", 8'h21, 8'h0F); adv();
        cpu_wr(8'h21, 8'h03);
        cpu_wr(8'h30, 8'h01);
        cpu_wr(8'h31, 8'h02);
        cpu_wr(8'h32, 8'h03);
        cpu_wr(8'h33, 8'h04);
        cpu_wr(8'h35, 8'h10);
        cpu_rd("buf5", 8'h35, 8'h10); adv();
        cpu_rd("len", 8'h21, 8'h03); adv();

        // Basic scroll: EN set, first write 5 cycles later
        cpu_wr(8'h20, 8'h01);
        repeat (4) adv();
        #1 expect_idle("pre_f1");
        adv();
        for (int i = 0; i < 8; i++) begin
            #1 expect_wr($sformatf("f1_d%0d", i), i[7:0], exp_f1[i]);
            adv();
        end
        cpu_rd("off_f1", 8'h23, 8'h01);
        chk("off_f1_rden", {7'd0, drv_read_en}, 8'd1);
        adv();

        // Second frame with a 2-cycle CPU preemption after d=0
        #1 expect_wr("f2_d0", 8'd0, exp_f2[0]);
        adv();
        cpu_req = 1'b1; cpu_read_en = 1'b0; cpu_addr = 8'h08; cpu_din = 8'hAA;
        #1 expect_wr("pre1", 8'h08, 8'hAA);
        @(negedge clk);
        #1 expect_wr("pre2", 8'h08, 8'hAA);
        @(negedge clk);
        cpu_rd("ctrl_busy", 8'h20, 8'h03);
        expect_wr("f2_d1", 8'd1, exp_f2[1]);
        adv();
        for (int i = 2; i < 8; i++) begin
            #1 expect_wr($sformatf("f2_d%0d", i), i[7:0], exp_f2[i]);
            adv();
        end
        cpu_rd("ctrl_idle", 8'h20, 8'h01);
        chk("f2_end_rden", {7'd0, drv_read_en}, 8'd1);
        adv();

        // Third frame (offset 2), EN cleared during the d=2 write
        #1 expect_wr("f3_d0", 8'd0, 8'd3);
        adv();
        #1 expect_wr("f3_d1", 8'd1, 8'd4);
        adv();
        cpu_req = 1'b1; cpu_read_en = 1'b0; cpu_addr = 8'h20; cpu_din = 8'h00;
        #1 expect_wr("f3_d2", 8'd2, 8'd1);
        adv();
        cpu_rd("off_abort", 8'h23, 8'h02);
        chk("abort_rden", {7'd0, drv_read_en}, 8'd1);
        adv();
        cpu_rd("ctrl_abort", 8'h20, 8'h00);
        adv();
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("off_rden%0d", i), {7'd0, drv_read_en}, 8'd1);
            adv();
        end

        // Reset asserted mid-frame (offset 2, d=2 -> BUF[0])
        cpu_wr(8'h20, 8'h01);
        repeat (7) adv();
        #1 expect_wr("rf_d2", 8'd2, 8'd1);
        #1 nrst = 1'b0;
        #1 expect_idle("async_rst");
        chk("async_rst_hit", {7'd0, ctrl_hit}, 8'd0);
        repeat (2) @(negedge clk);
        #1 expect_idle("in_rst");
        @(negedge clk);
        nrst = 1'b1;

        // Defaults after reset: RATE=0 acts as 1, LEN=0 repeats BUF[0]
        cpu_rd("off_rst", 8'h23, 8'h00); adv();
        cpu_wr(8'h22, 8'h00);
        cpu_wr(8'h21, 8'h00);
        cpu_wr(8'h30, 8'h5A);
        cpu_wr(8'h31, 8'h77);
        cpu_rd("rate0", 8'h22, 8'h00); adv();
        cpu_wr(8'h20, 8'h01);
        repeat (4) adv();
        #1 expect_idle("pre_f4");
        adv();
        for (int i = 0; i < 8; i++) begin
            #1 expect_wr($sformatf("f4_d%0d", i), i[7:0], 8'h5A);
            adv();
        end
        cpu_rd("off_f4", 8'h23, 8'h00);
        adv();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
